// File: rtl/key_conditioner.sv
// key_conditioner: N-channel push-button front end.
// Each channel runs through a synchroniser, a debouncer and an edge
// detector. Channels selected by REPEAT_MASK also get hold-to-repeat, so a
// held key keeps producing fire pulses. All outputs are registered, and
// press/release_pulse/fire are one-cycle pulses in the clk domain.
// The falling-edge output is named release_pulse because "release" is a
// reserved word in SystemVerilog.
module key_conditioner #(
    parameter int                  CHANNELS        = 4,
    parameter int                  SYNC_STAGES     = 2,
    parameter int                  DEBOUNCE_CYCLES = 250000,
    parameter int                  REPEAT_DELAY    = 4000000,
    parameter int                  REPEAT_RATE     = 1000000,
    parameter logic [CHANNELS-1:0] REPEAT_MASK     = 4'b1011
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] key_in,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] fire
);

    localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RC_W    = $clog2(RPT_MAX) + 1;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RC_W-1:0]  DELAY_LAST = RC_W'(REPEAT_DELAY - 1);
    localparam logic [RC_W-1:0]  RATE_LAST  = RC_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_e;

    logic [SYNC_STAGES-1:0] sync_q  [CHANNELS];
    logic [CNT_W-1:0]       cnt_q   [CHANNELS];
    rpt_state_e             state_q [CHANNELS];
    logic [RC_W-1:0]        rc_q    [CHANNELS];

    logic [CHANNELS-1:0] synced;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;

    // Shift each raw key level through its synchroniser chain.
    always_ff @(posedge clk) begin
        // NOTE: every state element, including the per-channel arrays, is
        // cleared explicitly here. There is no memory macro behind these
        // arrays, so nothing would clear them for us.
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                // NOTE: non-blocking assignment, so each stage samples the
                // value its neighbour held before this edge.
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], key_in[i]};
            end
        end
    end

    // Decode the edge at which a debounced level is about to change.
    always_comb begin
        // NOTE: default every output of this block first, so no path
        // leaves a bit unassigned and no latch is inferred.
        synced = '0;
        rise   = '0;
        fall   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            synced[i] = sync_q[i][SYNC_STAGES-1];
            if ((synced[i] != level[i]) && (cnt_q[i] == CNT_LAST)) begin
                rise[i] = synced[i];
                fall[i] = ~synced[i];
            end
        end
    end

    // Debounce counters, stable levels, and the press/release pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            level         <= '0;
            press         <= '0;
            release_pulse <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            press         <= rise;
            release_pulse <= fall;
            for (int i = 0; i < CHANNELS; i++) begin
                if (synced[i] == level[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    level[i] <= synced[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Per-channel hold-to-repeat FSM, with fire registered alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            fire <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= RPT_IDLE;
                rc_q[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                fire[i] <= rise[i];
                if (!REPEAT_MASK[i]) begin
                    state_q[i] <= RPT_IDLE;
                    rc_q[i]    <= '0;
                end else if (fall[i]) begin
                    // A release wins over a repeat that lands on the same edge.
                    state_q[i] <= RPT_IDLE;
                    rc_q[i]    <= '0;
                end else begin
                    case (state_q[i])
                        RPT_IDLE: begin
                            if (rise[i]) begin
                                state_q[i] <= RPT_DELAY;
                                rc_q[i]    <= '0;
                            end
                        end
                        RPT_DELAY: begin
                            if (rc_q[i] == DELAY_LAST) begin
                                fire[i]    <= 1'b1;
                                rc_q[i]    <= '0;
                                state_q[i] <= RPT_REPEAT;
                            end else begin
                                rc_q[i] <= rc_q[i] + RC_W'(1);
                            end
                        end
                        RPT_REPEAT: begin
                            if (rc_q[i] == RATE_LAST) begin
                                fire[i] <= 1'b1;
                                rc_q[i] <= '0;
                            end else begin
                                rc_q[i] <= rc_q[i] + RC_W'(1);
                            end
                        end
                        default: begin
                            state_q[i] <= RPT_IDLE;
                            rc_q[i]    <= '0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Testbench for key_conditioner: directed steps followed by randomised key
// activity, compared every cycle against a behavioural model.
module tb_key_conditioner;

    localparam int         CH   = 4;
    localparam int         SS   = 2;
    localparam int         DB   = 4;
    localparam int         RD   = 10;
    localparam int         RR   = 3;
    localparam logic [3:0] MASK = 4'b0001;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] key_in;
    logic [CH-1:0] level;
    logic [CH-1:0] press;
    logic [CH-1:0] release_pulse;
    logic [CH-1:0] fire;

    key_conditioner #(
        .CHANNELS       (CH),
        .SYNC_STAGES    (SS),
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR),
        .REPEAT_MASK    (MASK)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_in       (key_in),
        .level        (level),
        .press        (press),
        .release_pulse(release_pulse),
        .fire         (fire)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    string phase  = "init";

    // Reference model state.
    logic [CH-1:0] m_dl [SS];   // the key level as seen SS edges later
    logic [CH-1:0] m_level;
    int            m_run [CH];  // consecutive cycles synced has differed from level
    int            m_t0  [CH];  // edge index at which the key was last pressed
    int            edge_n = 0;
    logic [CH-1:0] e_level, e_press, e_rel, e_fire;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s: observed 0x%0h expected 0x%0h", phase, tag, obs, exp);
        end
    endtask

    // Work out what the design should register at this edge, from the
    // rules: a level change is accepted after DB consecutive cycles of
    // disagreement, and a held masked key fires at ages 0, RD, RD+RR, ...
    task automatic model_edge();
        logic [CH-1:0] synced;
        int            age;
        edge_n++;
        e_press = '0;
        e_rel   = '0;
        e_fire  = '0;
        if (rst) begin
            for (int s = 0; s < SS; s++) m_dl[s] = '0;
            m_level = '0;
            for (int i = 0; i < CH; i++) m_run[i] = 0;
        end else begin
            synced = m_dl[SS-1];
            for (int s = SS - 1; s > 0; s--) m_dl[s] = m_dl[s-1];
            m_dl[0] = key_in;
            for (int i = 0; i < CH; i++) begin
                if (synced[i] !== m_level[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_level[i] = synced[i];
                        m_run[i]   = 0;
                        if (synced[i]) begin
                            e_press[i] = 1'b1;
                            m_t0[i]    = edge_n;
                        end else begin
                            e_rel[i] = 1'b1;
                        end
                    end
                end else begin
                    m_run[i] = 0;
                end
                age = edge_n - m_t0[i];
                if (e_press[i])
                    e_fire[i] = 1'b1;
                else if (MASK[i] && m_level[i] && age >= RD && ((age - RD) % RR) == 0)
                    e_fire[i] = 1'b1;
            end
        end
        e_level = m_level;
    endtask

    // One clock: drive while clk is low, update the model on the rising
    // edge, compare on the falling edge.
    task automatic cycle(input logic [CH-1:0] k, input logic r);
        key_in = k;
        rst    = r;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("level",   level,         e_level);
        check("press",   press,         e_press);
        check("release", release_pulse, e_rel);
        check("fire",    fire,          e_fire);
        check("press_and_release", press & release_pulse, 0);
    endtask

    initial begin
        int fq [$];
        int exp_f [8];
        int f0, f1, lv, p, len;
        logic [CH-1:0] k;
        logic          r;

        exp_f  = '{0, 10, 13, 16, 19, 22, 25, 28};
        key_in = '0;
        rst    = 1'b1;
        m_level = '0;
        for (int s = 0; s < SS; s++) m_dl[s] = '0;
        for (int i = 0; i < CH; i++) begin
            m_run[i] = 0;
            m_t0[i]  = 0;
        end

        // Reset with every key held: outputs stay quiet, then one press each.
        phase = "reset";
        cycle(4'hF, 1'b1);
        cycle(4'hF, 1'b1);
        check("outputs_in_reset", {level, press, release_pulse, fire}, 0);
        for (int s = 1; s <= 8; s++) begin
            cycle(4'hF, 1'b0);
            if (s == 1) check("outputs_after_reset", {level, press, release_pulse, fire}, 0);
            check("press_after_reset", press, (s == 6) ? 4'hF : 4'h0);
        end
        for (int s = 0; s < 12; s++) cycle(4'h0, 1'b0);

        // Channel 1 (no repeat): a single press/fire, then a release.
        phase = "ch1_hold";
        f1 = 0;
        for (int s = 1; s <= 20; s++) begin
            cycle(4'b0010, 1'b0);
            if (s == 6) check("ch1_press", press, 4'b0010);
            f1 += int'(fire[1]);
        end
        check("ch1_fire_count", f1, 1);
        for (int s = 1; s <= 10; s++) begin
            cycle(4'h0, 1'b0);
            if (s == 6) check("ch1_release", release_pulse, 4'b0010);
        end

        // Channel 2 glitches shorter than the debounce window are ignored.
        phase = "ch2_glitch";
        lv = 0;
        for (int b = 0; b < 3; b++) begin
            for (int s = 0; s < 3; s++) begin
                cycle((b % 2 == 0) ? 4'b0100 : 4'b0000, 1'b0);
                lv |= int'(level[2] | press[2] | release_pulse[2]);
            end
        end
        for (int s = 0; s < 10; s++) begin
            cycle(4'h0, 1'b0);
            lv |= int'(level[2] | press[2] | release_pulse[2]);
        end
        check("ch2_no_activity", lv, 0);

        // Channel 0 held: fire spacing is press, +RD, then every RR.
        phase = "ch0_repeat";
        p = -1;
        for (int s = 1; s <= 34; s++) begin
            cycle(4'b0001, 1'b0);
            if (press[0]) p = s;
            if (fire[0] && p >= 0) fq.push_back(s - p);
        end
        check("ch0_fire_count", fq.size(), 8);
        for (int j = 0; j < 8; j++)
            check("ch0_fire_time", (j < fq.size()) ? fq[j] : -1, exp_f[j]);

        // The drop lands the level fall on the edge of a due repeat.
        phase = "ch0_release_vs_repeat";
        for (int s = 35; s <= 40; s++) begin
            cycle(4'h0, 1'b0);
            if (s == 40) begin
                check("ch0_release", release_pulse[0], 1);
                check("ch0_no_fire", fire[0], 0);
            end
        end
        for (int s = 0; s < 14; s++) cycle(4'h0, 1'b0);

        // Two channels together: one shared press cycle, only ch0 repeats.
        phase = "ch01_together";
        f0 = 0;
        f1 = 0;
        for (int s = 1; s <= 20; s++) begin
            cycle(4'b0011, 1'b0);
            if (s == 6) check("ch01_press", press, 4'b0011);
            f0 += int'(fire[0]);
            f1 += int'(fire[1]);
        end
        check("ch0_fire_count_20", f0, 3);
        check("ch1_fire_count_20", f1, 1);
        for (int s = 0; s < 12; s++) cycle(4'h0, 1'b0);

        // Randomised key activity with the occasional reset.
        phase = "random";
        for (int seg = 0; seg < 100; seg++) begin
            r   = ($urandom_range(0, 24) == 0);
            k   = CH'($urandom);
            len = r ? 1 : int'($urandom_range(1, 9));
            for (int s = 0; s < len; s++) cycle(k, r);
        end
        for (int s = 0; s < 40; s++) cycle(4'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
